// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state type and register-bank constants for the operand fetch controller
package cpu_pkg;
   typedef enum logic [2:0] {IDLE, RD_A, RD_B, LD_B, LD_A, ISS} ofc_state_t;
   localparam int REG_AW = 4;
   localparam logic [3:0] ACC_ADDR = 4'd0;
endpackage

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: serializes Op1/Op2 reads over the shared register-bank port and strobes the operand latches
// Optional build macro OPFETCH_ACC_BYPASS_EN: operands addressing R0 load straight from the accumulator.
import cpu_pkg::*;
module operand_fetch_ctrl #(
   parameter int AW = REG_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dec_valid,
   output logic          dec_ready,
   input  logic [AW-1:0] dec_op1_addr,
   input  logic [AW-1:0] dec_op2_addr,
   input  logic          dec_use_op2,
   output logic          rf_rd_en,
   output logic [AW-1:0] rf_rd_addr,
   output logic          op1_load,
   output logic          op2_load,
   output logic          op1_src_acc,
   output logic          op2_src_acc,
   output logic [AW-1:0] op1_addr_q,
   output logic [AW-1:0] op2_addr_q,
   output logic          ex_valid,
   input  logic          ex_ready,
   output logic          busy
);
`ifdef OPFETCH_ACC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam logic [AW-1:0] ACC = AW'(ACC_ADDR);
   ofc_state_t state, state_n;
   logic use2_q, acc_cyc;
   // a*: operand comes from the accumulator; p*: operand needs its own port read;
   // dup: Op2 equals a port-read Op1 and rides on the same read
   logic a1, a2, p1, p2, dup, none, new_none;
   assign a1 = BYP && op1_addr_q == ACC;
   assign a2 = BYP && use2_q && op2_addr_q == ACC;
   assign p1 = !a1;
   assign dup = use2_q && !a2 && p1 && op1_addr_q == op2_addr_q;
   assign p2 = use2_q && !a2 && !dup;
   assign none = !p1 && !p2;
   assign new_none = BYP && dec_op1_addr == ACC && (!dec_use_op2 || dec_op2_addr == ACC);
   // state register and request capture on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op1_addr_q <= '0;
         op2_addr_q <= '0;
         use2_q     <= 1'b0;
      end else begin
         state <= state_n;
         if (dec_valid && dec_ready) begin
            op1_addr_q <= dec_op1_addr;
            op2_addr_q <= dec_op2_addr;
            use2_q     <= dec_use_op2;
         end
      end
   end
   // next state and per-state strobes; acc loads land in the first post-accept cycle
   always_comb begin
      dec_ready   = state == IDLE;
      busy        = state != IDLE;
      ex_valid    = state == ISS;
      rf_rd_en    = state == RD_A || state == RD_B;
      rf_rd_addr  = state == RD_B ? op2_addr_q : state == RD_A ? (p1 ? op1_addr_q : op2_addr_q) : '0;
      acc_cyc     = state == RD_A || (state == LD_A && none);
      op1_src_acc = acc_cyc && a1;
      op2_src_acc = acc_cyc && a2;
      op1_load    = op1_src_acc || state == RD_B || (state == LD_A && p1);
      op2_load    = op2_src_acc || state == LD_B || (state == LD_A && (p2 || dup));
      case (state)
         IDLE:    state_n = dec_valid ? (new_none ? LD_A : RD_A) : IDLE;
         RD_A:    state_n = p1 && p2 ? RD_B : LD_A;
         RD_B:    state_n = LD_B;
         LD_B:    state_n = ISS;
         LD_A:    state_n = ISS;
         ISS:     state_n = ex_ready ? IDLE : ISS;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb_operand_fetch_ctrl: directed and random requests checked against a per-request schedule model
module tb_operand_fetch_ctrl;
`ifdef OPFETCH_ACC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, dec_valid, dec_ready, dec_use_op2, rf_rd_en, op1_load, op2_load;
   logic op1_src_acc, op2_src_acc, ex_valid, ex_ready, busy;
   logic [3:0] dec_op1_addr, dec_op2_addr, rf_rd_addr, op1_addr_q, op2_addr_q;
   logic [3:0] eq1 = 4'd0, eq2 = 4'd0;
   logic [3:0] rd [2];
   int n, t1, t2, e;
   bit s1, s2;
   int passes = 0, fails = 0, checks = 0;
   always #5 clk = ~clk;
   operand_fetch_ctrl dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_op1_addr(dec_op1_addr), .dec_op2_addr(dec_op2_addr), .dec_use_op2(dec_use_op2),
      .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .op1_load(op1_load), .op2_load(op2_load),
      .op1_src_acc(op1_src_acc), .op2_src_acc(op2_src_acc), .op1_addr_q(op1_addr_q),
      .op2_addr_q(op2_addr_q), .ex_valid(ex_valid), .ex_ready(ex_ready), .busy(busy)
   );
   function automatic logic [15:0] pack(input bit dr, input bit bz, input bit en, input logic [3:0] ad,
                                        input bit l1, input bit l2, input bit c1, input bit c2, input bit ev);
      return {4'b0, dr, bz, en, ad, l1, l2, c1, c2, ev};
   endfunction
   function automatic logic [15:0] obs();
      return pack(dec_ready, busy, rf_rd_en, rf_rd_addr, op1_load, op2_load, op1_src_acc, op2_src_acc, ex_valid);
   endfunction
   function automatic logic [15:0] idle_vec();
      return pack(1, 0, 0, 4'd0, 0, 0, 0, 0, 0);
   endfunction
   // expected outputs k cycles after the accept edge, from the read list and load schedule
   function automatic logic [15:0] exp_at(input int k);
      return pack(0, 1, k <= n, k <= n ? rd[k-1] : 4'd0, k == t1, k == t2, s1 && k == 1, s2 && k == 1, k == e);
   endfunction
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // reads go to the port in Op1, Op2 order; each latch loads the cycle after its read,
   // acc operands load in cycle 1, a duplicate Op2 loads with Op1
   task automatic plan(input logic [3:0] a, input logic [3:0] b, input bit u);
      bit acc1, acc2;
      acc1 = BYP && a == 4'd0;
      acc2 = u && BYP && b == 4'd0;
      n = 0; t1 = 0; t2 = 0;
      if (acc1) t1 = 1;
      else begin rd[n] = a; n++; t1 = n + 1; end
      if (u) begin
         if (acc2) t2 = 1;
         else if (!acc1 && a == b) t2 = t1;
         else begin rd[n] = b; n++; t2 = n + 1; end
      end
      e = n == 0 ? 2 : n + 2;
      s1 = acc1; s2 = acc2;
   endtask
   task automatic accept(input logic [3:0] a, input logic [3:0] b, input bit u);
      chk("idle", obs(), idle_vec());
      chk("idle_q", {8'b0, op1_addr_q, op2_addr_q}, {8'b0, eq1, eq2});
      dec_valid = 1; dec_op1_addr = a; dec_op2_addr = b; dec_use_op2 = u;
      ex_ready = 1'($urandom);
      step();
      eq1 = a; eq2 = b;
      plan(a, b, u);
   endtask
   task automatic run_req(input logic [3:0] a, input logic [3:0] b, input bit u, input int w);
      accept(a, b, u);
      for (int k = 1; k < e; k++) begin
         chk($sformatf("c%0d", k), obs(), exp_at(k));
         chk("q", {8'b0, op1_addr_q, op2_addr_q}, {8'b0, eq1, eq2});
         dec_valid = 1'($urandom); dec_op1_addr = 4'($urandom); dec_op2_addr = 4'($urandom);
         ex_ready = 1'($urandom);
         step();
      end
      for (int i = 0; i <= w; i++) begin
         chk($sformatf("iss%0d", i), obs(), exp_at(e));
         chk("iss_q", {8'b0, op1_addr_q, op2_addr_q}, {8'b0, eq1, eq2});
         dec_valid = 1'(i < w || $urandom_range(0, 1) == 1);
         dec_op1_addr = 4'($urandom); dec_op2_addr = 4'($urandom);
         ex_ready = i == w;
         step();
      end
      dec_valid = 0;
   endtask
   initial begin
      rst = 1; dec_valid = 0; ex_ready = 0; dec_use_op2 = 0; dec_op1_addr = 0; dec_op2_addr = 0;
      step();
      chk("rst", obs(), idle_vec());
      chk("rst_q", {8'b0, op1_addr_q, op2_addr_q}, 16'h0);
      step();
      rst = 0;
      run_req(4'd3, 4'd5, 1, 0);
      run_req(4'd7, 4'd2, 0, 0);
      run_req(4'd9, 4'd9, 1, 5);
      run_req(4'd0, 4'd4, 1, 1);
      run_req(4'd0, 4'd0, 1, 0);
      run_req(4'd0, 4'd6, 0, 0);
      run_req(4'd4, 4'd0, 1, 2);
      accept(4'd3, 4'd5, 1);
      dec_valid = 0;
      chk("rb_c1", obs(), exp_at(1));
      step();
      chk("rb_c2", obs(), exp_at(2));
      rst = 1;
      step();
      rst = 0;
      eq1 = 0; eq2 = 0;
      chk("rb_idle", obs(), idle_vec());
      chk("rb_q", {8'b0, op1_addr_q, op2_addr_q}, 16'h0);
      run_req(4'd11, 4'd12, 1, 0);
      accept(4'd7, 4'd1, 0);
      dec_valid = 0;
      for (int k = 1; k < e; k++) step();
      chk("ri_iss", obs(), exp_at(e));
      ex_ready = 1; rst = 1;
      step();
      rst = 0; ex_ready = 0;
      eq1 = 0; eq2 = 0;
      chk("ri_idle", obs(), idle_vec());
      chk("ri_q", {8'b0, op1_addr_q, op2_addr_q}, 16'h0);
      for (int r = 0; r < 40; r++) begin
         logic [3:0] a, b;
         a = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom);
         b = $urandom_range(0, 3) == 0 ? a : ($urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom));
         run_req(a, b, 1'($urandom), $urandom_range(0, 3));
      end
      chk("end_idle", obs(), idle_vec());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/operand_fetch_ctrl.md
# operand_fetch_ctrl

Sequences operand fetch for the 16-bit CPU: takes decoded operand addresses from decode, drives the single shared register-bank read port, and pulses the load strobes of the Op1 and Op2 operand latches in the right cycles. When both operands are loaded, it presents a valid/ready handshake to execute. It sits between the decoder, the register bank read port, and the two operand latches. Op1 and Op2 share one register bank, so their reads are serialized here.

## Interface
- `AW`, default 4: register address width (16 registers; R0 is the accumulator).
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `dec_valid`, in, 1: decoder presents an operand request.
- `dec_ready`, out, 1: controller accepts a request (high only in IDLE).
- `dec_op1_addr`, in, AW: Op1 register address.
- `dec_op2_addr`, in, AW: Op2 register address.
- `dec_use_op2`, in, 1: instruction needs Op2.
- `rf_rd_en`, out, 1: register bank read enable.
- `rf_rd_addr`, out, AW: register bank read address. The bank returns data one cycle later.
- `op1_load`, out, 1: Op1 latch load strobe.
- `op2_load`, out, 1: Op2 latch load strobe.
- `op1_src_acc`, out, 1: Op1 input mux selects the accumulator (bypass build only; else 0).
- `op2_src_acc`, out, 1: Op2 input mux selects the accumulator (bypass build only; else 0).
- `op1_addr_q`, out, AW: registered Op1 address of the request in flight.
- `op2_addr_q`, out, AW: registered Op2 address of the request in flight.
- `ex_valid`, out, 1: both operands are loaded and available to execute.
- `ex_ready`, in, 1: execute consumes the operands.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RD_A, RD_B, LD_B, LD_A, ISS.
- Accept: a handshake fires on `dec_valid && dec_ready`. The addresses and use flag are captured into `op1_addr_q`, `op2_addr_q` and an internal `use2_q`.
- Two distinct reads (`use2`, `op1 != op2`):
  - IDLE → RD_A: drive `rf_rd_addr = op1`.
  - RD_B: drive `rf_rd_addr = op2`; assert `op1_load`.
  - LD_B: assert `op2_load`.
  - → ISS.
- Single read (`!use2`, or `op1 == op2`):
  - IDLE → RD_A: drive `rf_rd_addr = op1`.
  - LD_A: assert `op1_load`, plus `op2_load` if `use2`.
  - → ISS.
- ISS: `ex_valid = 1` and held until `ex_ready`, then → IDLE. A new request can be accepted on the following cycle, so there is always at least one bubble between requests.
- `rf_rd_en` is high exactly in RD_A and RD_B.
- Load strobes are single-cycle pulses.
- `op2_load` is never asserted when `!use2`.
- Address registers hold their value until the next accept.

## Timing
- Reset values: state IDLE; `dec_ready = 1`; all other outputs 0, including the address registers.
- Latency from accept edge (cycle 0) to first `ex_valid` cycle:
  - two reads: 4 cycles (RD_A=1, RD_B=2, LD_B=3, ISS=4);
  - single read: 3 cycles.
- Read data must be captured by the latch in the cycle after its address cycle; the load strobe is asserted in that data cycle.
- `rst` asserted in any state: state is IDLE and outputs are at reset values after that edge. An in-flight request is dropped with no load strobe. `ex_valid` drops even if `ex_ready` was high in the same cycle.
- `dec_valid` arriving while busy is ignored; the decoder must hold it until `dec_ready`.
- `ex_ready` outside ISS has no effect.

## Configuration
- Macro: `OPFETCH_ACC_BYPASS_EN`.
- Defined: an operand addressing R0 bypasses the read port.
  - Its `opN_src_acc` and `opN_load` are asserted together in the first post-accept cycle.
  - Only non-R0 operands use RD_A/RD_B sequencing, ordered Op1 then Op2.
  - No port operands at all: a single LD_A cycle with the acc loads, then ISS (latency 2).
  - One port operand: latency 3, with the acc load coinciding with RD_A.
  - `op1 == op2 == 0`: both operands come from the acc.
- Undefined: `op*_src_acc` are tied to 0 and R0 is read through the port like any register.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum `ofc_state_t`;
  - `REG_AW = 4`;
  - `ACC_ADDR = 4'd0`.
- No sub-module: a single flat FSM plus address registers.

## Test plan
- Reset, then accept op1=3, op2=5, use2=1 → `rf_rd_addr` reads 3 then 5 in cycles 1–2; `op1_load` in cycle 2; `op2_load` in cycle 3; `ex_valid` in cycle 4.
- op1=7, use2=0 → single read of 7; only `op1_load` in cycle 2; `ex_valid` in cycle 3; `op2_load` never high.
- op1=op2=9, use2=1 → exactly one read of 9; `op1_load` and `op2_load` both in cycle 2.
- `ex_ready` held low for 5 cycles in ISS → `ex_valid` stays 1 and `dec_ready` stays 0; a `dec_valid` pulse during that time is not accepted.
- `rst` pulsed in RD_B → next cycle IDLE, no `op2_load`, `ex_valid` 0, and a new request is accepted normally.
- Bypass build: op1=0, op2=4 → `op1_src_acc` and `op1_load` in cycle 1 together with a read of 4; `op2_load` in cycle 2; `ex_valid` in cycle 3.
